// File: rtl/serial_adder.sv
// serial_adder: bit-serial A + B + Cin using one full-adder cell.
// One bit pair per clock, LSB first; result registered on completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_a;
    logic             fa_b;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    // The LSB of the sum shift register is always shifted out before use.
    logic             sum_lsb_unused;

    assign sum_lsb_unused = sum_sr[0];

    // Single full-adder cell fed from the operand LSBs and registered carry.
    assign fa_a = a_sr[0];
    assign fa_b = b_sr[0];
    assign fa_s = fa_a ^ fa_b ^ carry;
    assign fa_c = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);

    // Completion is the edge that processes bit WIDTH-1.
    assign last = (cnt == CW'(WIDTH - 1));

    // New sum bits enter at the MSB so bit 0 lands at S[0] after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nx = fa_s;
        end else begin : g_sum_wn
            assign sum_nx = {fa_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // Moore outputs decoded straight from the state register.
    assign busy = (state == ADD);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit shifting and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    carry  <= fa_c;
                    sum_sr <= sum_nx;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        S    <= sum_nx;
                        Cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed stimulus for serial_adder
// (WIDTH=8 and WIDTH=1) against a timeline/arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       st8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       bz8;
    logic       dn8;
    logic [7:0] s8;
    logic       co8;

    logic       st1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       c1 = 1'b0;
    logic       bz1;
    logic       dn1;
    logic       s1;
    logic       co1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8),
        .A(a8), .B(b8), .Cin(c8),
        .busy(bz8), .done(dn8), .S(s8), .Cout(co8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1),
        .A(a1), .B(b1), .Cin(c1),
        .busy(bz1), .done(dn1), .S(s1), .Cout(co1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields A+B+Cin after WIDTH
    // further edges, shown for one cycle with done, then held.
    bit       m8_busy, m8_done;
    int       m8_left;
    logic [8:0] m8_pend, m8_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_busy = 0; m8_done = 0; m8_left = 0; m8_res = '0;
        end else if (m8_done) begin
            m8_done = 0;
        end else if (m8_busy) begin
            m8_left--;
            if (m8_left == 0) begin
                m8_busy = 0; m8_done = 1; m8_res = m8_pend;
            end
        end else if (st8) begin
            m8_pend = 9'(a8) + 9'(b8) + 9'(c8);
            m8_left = 8;
            m8_busy = 1;
        end
    end

    bit       m1_busy, m1_done;
    int       m1_left;
    logic [1:0] m1_pend, m1_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_busy = 0; m1_done = 0; m1_left = 0; m1_res = '0;
        end else if (m1_done) begin
            m1_done = 0;
        end else if (m1_busy) begin
            m1_left--;
            if (m1_left == 0) begin
                m1_busy = 0; m1_done = 1; m1_res = m1_pend;
            end
        end else if (st1) begin
            m1_pend = 2'(a1) + 2'(b1) + 2'(c1);
            m1_left = 1;
            m1_busy = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy8", 32'(bz8), 32'(m8_busy));
            chk("done8", 32'(dn8), 32'(m8_done));
            chk("sum8", {23'd0, co8, s8}, {23'd0, m8_res});
            chk("busy1", 32'(bz1), 32'(m1_busy));
            chk("done1", 32'(dn1), 32'(m1_done));
            chk("sum1", {30'd0, co1, s1}, {30'd0, m1_res});
        end
    end

    // Called at a negedge; returns result seen with done and the edge count.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input bit noisy,
                       output logic [8:0] res, output int lat);
        a8 = a; b8 = b; c8 = c; st8 = 1'b1;
        lat = 0;
        @(negedge clk);
        lat = 1;
        st8 = 1'b0;
        while (!dn8 && lat < 40) begin
            if (noisy) begin
                st8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        st8 = 1'b0;
        res = {co8, s8};
        if (lat >= 40) chk("timeout8", 32'(lat), 32'd9);
        @(negedge clk);
    endtask

    logic [1:0] tbl1 [8];
    logic [8:0] res;
    logic [8:0] exp9;
    logic [7:0] ra, rb;
    logic       rc;
    int         lat;
    int         prev;
    int         k;

    initial begin
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bz8), 32'd0);
        chk("rst_done", 32'(dn8), 32'd0);
        chk("rst_sum", {23'd0, co8, s8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'hFF, 8'h01, 1'b0, 0, res, lat);
        chk("ff01_lat", 32'(lat), 32'd9);
        chk("ff01_sum", 32'(res), 32'h100);

        op8(8'h3C, 8'h42, 1'b0, 0, res, lat);
        chk("3c42_sum", 32'(res), 32'h07E);

        op8(8'hA5, 8'h5A, 1'b1, 1, res, lat);
        chk("a55a_noisy_lat", 32'(lat), 32'd9);
        chk("a55a_noisy_sum", 32'(res), 32'h100);
        chk("idle_after_noise", 32'(bz8), 32'd0);

        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        st8 = 1'b1;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!dn8 && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (k >= 40) begin
                chk("timeout_thru", 32'(k), 32'd0);
                break;
            end
            if (i > 0) chk("spacing", 32'(cyc - prev), 32'd10);
            prev = cyc;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            @(negedge clk);
        end
        st8 = 1'b0;
        @(negedge clk);

        a8 = 8'h77; b8 = 8'h99; c8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bz8), 32'd0);
        chk("abort_done", 32'(dn8), 32'd0);
        chk("abort_sum", {23'd0, co8, s8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        op8(8'h12, 8'h34, 1'b1, 0, res, lat);
        chk("post_abort_sum", 32'(res), 32'h047);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, 1'($urandom), res, lat);
            chk("rand_lat", 32'(lat), 32'd9);
            chk("rand_sum", 32'(res), 32'(exp9));
        end

        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i);
            st1 = 1'b1;
            @(negedge clk);
            st1 = 1'b0;
            chk("w1_busy", 32'(bz1), 32'd1);
            @(negedge clk);
            chk("w1_done", 32'(dn1), 32'd1);
            chk("w1_sum", {30'd0, co1, s1}, {30'd0, tbl1[i]});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
